// File: rtl/pixel_sink_fb_writer_if.sv
// Framebuffer write port: the writer raises a request that stays stable
// until the memory accepts it with mem_ready.
interface pixel_sink_fb_writer_if #(
  parameter int ADDR_W = 15
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_data;
  logic              mem_ready;

  modport master (output mem_we, output mem_addr, output mem_data, input mem_ready);
  modport slave  (input mem_we, input mem_addr, input mem_data, output mem_ready);
endinterface

// File: rtl/pixel_sink_fb_writer.sv
// Pixel sink: clips painter writes, queues them, drains them into a stallable
// framebuffer write port and turns the frame toggle into a post-drain commit pulse.
module pixel_sink_fb_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int ADDR_W     = 15
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  plot,
  input  logic [7:0]            x,
  input  logic [6:0]            y,
  input  logic [2:0]            colour,
  input  logic                  frame_toggle,
  pixel_sink_fb_writer_if.master fb,
  output logic                  frame_commit,
  output logic [ADDR_W-1:0]     pixel_count,
  output logic [7:0]            clip_count,
  output logic                  overflow,
  output logic                  busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 3;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_t;

  state_t            state_r, state_next_s;
  logic [ENT_W-1:0]  fifo_mem_r [FIFO_DEPTH];
  logic [ENT_W-1:0]  head_s;
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r, count_next_s;
  logic              in_range_s, fifo_full_s, fifo_nonempty_s;
  logic              push_s, pop_s, done_s, we_next_s, fire_s, toggle_edge_s;
  logic [ADDR_W-1:0] pix_addr_s;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [2:0]        mem_data_r;
  logic [ADDR_W-1:0] pixel_count_r;
  logic [7:0]        clip_count_r;
  logic              overflow_r, toggle_prev_r, commit_pending_r, frame_commit_r, busy_r;

  assign head_s = fifo_mem_r[rd_ptr_r];

  // Ingress decisions; fullness uses the registered count so a same-cycle pop never frees a slot
  always_comb begin
    in_range_s      = (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
    fifo_full_s     = (count_r == CNT_W'(FIFO_DEPTH));
    fifo_nonempty_s = (count_r != {CNT_W{1'b0}});
    push_s          = plot && in_range_s && !fifo_full_s;
    pix_addr_s      = ADDR_W'({y, 7'b0000000}) + ADDR_W'({y, 5'b00000}) + ADDR_W'(x);
    toggle_edge_s   = frame_toggle ^ toggle_prev_r;
    fire_s          = commit_pending_r && (state_r == ST_IDLE) && !fifo_nonempty_s && !push_s;
  end

  // FIFO occupancy update
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1'b1);
      2'b01:   count_next_s = count_r - CNT_W'(1'b1);
      default: count_next_s = count_r;
    endcase
  end

  // Drain FSM next state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fifo_nonempty_s) state_next_s = ST_WRITE;
        else                 state_next_s = ST_IDLE;
      end
      ST_WRITE: begin
        if (fb.mem_ready && !fifo_nonempty_s) state_next_s = ST_IDLE;
        else                                  state_next_s = ST_WRITE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Drain FSM outputs: the output registers act as the head stage of the queue
  always_comb begin
    pop_s     = 1'b0;
    done_s    = 1'b0;
    we_next_s = mem_we_r;
    case (state_r)
      ST_IDLE: begin
        pop_s     = fifo_nonempty_s;
        we_next_s = fifo_nonempty_s;
      end
      ST_WRITE: begin
        if (fb.mem_ready) begin
          done_s    = 1'b1;
          pop_s     = fifo_nonempty_s;
          we_next_s = fifo_nonempty_s;
        end else begin
          done_s    = 1'b0;
          pop_s     = 1'b0;
          we_next_s = 1'b1;
        end
      end
      default: begin
        pop_s     = 1'b0;
        we_next_s = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_r <= ST_IDLE;
    else         state_r <= state_next_s;
  end

  // FIFO storage; entries are only read after being written
  always_ff @(posedge CLOCK_50) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= {pix_addr_s, colour};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      count_r <= count_next_s;
    end
  end

  // Write request head stage
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mem_we_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      mem_data_r <= 3'b000;
    end else begin
      mem_we_r <= we_next_s;
      if (pop_s) begin
        mem_addr_r <= head_s[ENT_W-1:3];
        mem_data_r <= head_s[2:0];
      end
    end
  end

  // Statistics, frame commit tracking and busy flag
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pixel_count_r    <= {ADDR_W{1'b0}};
      clip_count_r     <= 8'h00;
      overflow_r       <= 1'b0;
      toggle_prev_r    <= 1'b0;
      commit_pending_r <= 1'b0;
      frame_commit_r   <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      if (fire_s)
        pixel_count_r <= {ADDR_W{1'b0}};
      else if (done_s && (pixel_count_r != {ADDR_W{1'b1}}))
        pixel_count_r <= pixel_count_r + ADDR_W'(1'b1);
      if (plot && !in_range_s && (clip_count_r != 8'hFF))
        clip_count_r <= clip_count_r + 8'h01;
      if (plot && in_range_s && fifo_full_s)
        overflow_r <= 1'b1;
      toggle_prev_r <= frame_toggle;
      // toggles arriving while a commit is already pending fold into it
      if (fire_s)             commit_pending_r <= 1'b0;
      else if (toggle_edge_s) commit_pending_r <= 1'b1;
      frame_commit_r <= fire_s;
      busy_r         <= (count_next_s != {CNT_W{1'b0}}) || we_next_s;
    end
  end

  assign fb.mem_we     = mem_we_r;
  assign fb.mem_addr   = mem_addr_r;
  assign fb.mem_data   = mem_data_r;
  assign frame_commit  = frame_commit_r;
  assign pixel_count   = pixel_count_r;
  assign clip_count    = clip_count_r;
  assign overflow      = overflow_r;
  assign busy          = busy_r;
endmodule

// File: tb/tb_pixel_sink_fb_writer.sv
// Self-checking bench for pixel_sink_fb_writer: queue-based reference model
// compared every cycle, plus directed scenarios with hand-computed values.
module tb_pixel_sink_fb_writer;
  localparam int DEPTH = 8;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        frame_toggle;
  logic        frame_commit;
  logic [14:0] pixel_count;
  logic [7:0]  clip_count;
  logic        overflow;
  logic        busy;

  pixel_sink_fb_writer_if #(.ADDR_W(15)) fb_if ();

  pixel_sink_fb_writer #(.FIFO_DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120), .ADDR_W(15)) dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .plot         (plot),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .frame_toggle (frame_toggle),
    .fb           (fb_if),
    .frame_commit (frame_commit),
    .pixel_count  (pixel_count),
    .clip_count   (clip_count),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // reference model state
  int mq[$];
  bit m_we, m_ovf, m_prev, m_pend, m_commit, m_busy;
  int m_addr, m_data, m_pix, m_clip;

  // observations of the DUT write port
  int log_addr[$];
  int log_data[$];
  bit prev_we;
  int prev_addr, prev_data, last_pc, pc_before_commit, commits_seen;

  task automatic model_reset();
    mq.delete();
    m_we = 0; m_ovf = 0; m_prev = 0; m_pend = 0; m_commit = 0; m_busy = 0;
    m_addr = 0; m_data = 0; m_pix = 0; m_clip = 0;
  endtask

  task automatic model_step();
    bit full, in_r, pushing, fire, tog_seen;
    int ent;
    full    = (mq.size() == DEPTH);
    in_r    = (int'(x) < 160) && (int'(y) < 120);
    pushing = plot && in_r && !full;
    fire    = m_pend && !m_we && (mq.size() == 0) && !pushing;
    if (m_we && fb_if.mem_ready) begin
      if (m_pix < 32767) m_pix++;
      m_we = 0;
    end
    if (!m_we && mq.size() > 0) begin
      ent    = mq.pop_front();
      m_addr = ent / 8;
      m_data = ent % 8;
      m_we   = 1;
    end
    if (plot) begin
      if (!in_r) begin
        if (m_clip < 255) m_clip++;
      end else if (full) m_ovf = 1;
      else mq.push_back((int'(y) * 160 + int'(x)) * 8 + int'(colour));
    end
    tog_seen = (frame_toggle != m_prev);
    m_prev   = frame_toggle;
    m_commit = fire;
    if (fire) begin
      m_pend = 0;
      m_pix  = 0;
    end else if (tog_seen) m_pend = 1;
    m_busy = (mq.size() > 0) || m_we;
  endtask

  // model update at each edge, comparison just after it
  initial begin
    model_reset();
    prev_we = 0; prev_addr = 0; prev_data = 0; last_pc = 0; pc_before_commit = -1; commits_seen = 0;
    forever begin
      @(posedge CLOCK_50);
      if (!resetn) model_reset();
      else begin
        if (prev_we && fb_if.mem_ready) begin
          log_addr.push_back(prev_addr);
          log_data.push_back(prev_data);
        end
        model_step();
      end
      #1;
      chk("mem_we", fb_if.mem_we, m_we);
      if (m_we) begin
        chk("mem_addr", fb_if.mem_addr, m_addr);
        chk("mem_data", fb_if.mem_data, m_data);
      end
      chk("pixel_count", pixel_count, m_pix);
      chk("clip_count", clip_count, m_clip);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, m_busy);
      chk("frame_commit", frame_commit, m_commit);
      if (frame_commit) begin
        commits_seen++;
        pc_before_commit = last_pc;
      end
      last_pc   = pixel_count;
      prev_we   = fb_if.mem_we;
      prev_addr = fb_if.mem_addr;
      prev_data = fb_if.mem_data;
    end
  end

  task automatic step(input bit p, input int xx, input int yy, input int cc);
    plot   = p;
    x      = 8'(xx);
    y      = 7'(yy);
    colour = 3'(cc);
    @(negedge CLOCK_50);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    plot = 1'b0;
    @(negedge CLOCK_50);
    while (busy && n < 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk(name, busy, 0);
    repeat (3) @(negedge CLOCK_50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int thr, n;
    resetn = 1'b0; plot = 1'b0; x = 8'd0; y = 7'd0; colour = 3'd0;
    frame_toggle = 1'b0; fb_if.mem_ready = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_we", fb_if.mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc", pixel_count, 0);
    chk("rst_clip", clip_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_commit", frame_commit, 0);
    resetn = 1'b1;
    fb_if.mem_ready = 1'b1;

    // single pixel latency
    step(1, 5, 3, 2);
    chk("t1_we_e0", fb_if.mem_we, 0);
    step(0, 0, 0, 0);
    chk("t1_we_e1", fb_if.mem_we, 1);
    chk("t1_addr", fb_if.mem_addr, 485);
    chk("t1_data", fb_if.mem_data, 2);
    step(0, 0, 0, 0);
    chk("t1_pc", pixel_count, 1);
    chk("t1_we_off", fb_if.mem_we, 0);

    // column of 120 back-to-back pixels
    log_addr.delete(); log_data.delete();
    for (int i = 0; i < 120; i++) step(1, 40, i, i % 8);
    drain("t2_drained");
    chk("t2_nwrites", log_addr.size(), 120);
    for (int i = 0; i < 120 && i < log_addr.size(); i++) chk("t2_addr", log_addr[i], 40 + 160 * i);
    chk("t2_ovf", overflow, 0);
    chk("t2_pc", pixel_count, 121);

    // stalled memory: 1 held + 8 queued, 10th dropped
    fb_if.mem_ready = 1'b0;
    log_addr.delete(); log_data.delete();
    for (int i = 0; i < 10; i++) step(1, i, 10, i % 8);
    chk("t3_ovf", overflow, 1);
    chk("t3_we", fb_if.mem_we, 1);
    chk("t3_addr_held", fb_if.mem_addr, 1600);
    fb_if.mem_ready = 1'b1;
    drain("t3_drained");
    chk("t3_nwrites", log_addr.size(), 9);
    for (int i = 0; i < 9 && i < log_addr.size(); i++) begin
      chk("t3_addr", log_addr[i], 1600 + i);
      chk("t3_data", log_data[i], i % 8);
    end
    chk("t3_pc", pixel_count, 130);

    // clipping boundaries
    log_addr.delete(); log_data.delete();
    step(1, 160, 0, 1);
    step(1, 0, 120, 1);
    step(1, 159, 119, 5);
    drain("t4_drained");
    chk("t4_clip", clip_count, 2);
    chk("t4_nwrites", log_addr.size(), 1);
    if (log_addr.size() > 0) begin
      chk("t4_addr", log_addr[0], 19199);
      chk("t4_data", log_data[0], 5);
    end

    // frame commit after the third write with a toggling ready
    frame_toggle = ~frame_toggle;
    repeat (4) step(0, 0, 0, 0);
    chk("t5_pc_clear", pixel_count, 0);
    commits_seen = 0;
    pc_before_commit = -1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) frame_toggle = ~frame_toggle;
      fb_if.mem_ready = ~fb_if.mem_ready;
      step(1, 10 + i, 20, i + 1);
    end
    n = 0;
    while (commits_seen == 0 && n < 60) begin
      fb_if.mem_ready = ~fb_if.mem_ready;
      step(0, 0, 0, 0);
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      fb_if.mem_ready = ~fb_if.mem_ready;
      step(0, 0, 0, 0);
    end
    chk("t5_commits", commits_seen, 1);
    chk("t5_pc_before", pc_before_commit, 3);
    chk("t5_pc_after", pixel_count, 0);

    // randomized traffic with varying memory stall rates
    for (int blk = 0; blk < 15; blk++) begin
      thr = 1 + (blk % 4);
      for (int c = 0; c < 100; c++) begin
        fb_if.mem_ready = (($urandom % 4) < thr);
        if (($urandom % 40) == 0) frame_toggle = ~frame_toggle;
        step(($urandom % 2) == 0, $urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7));
      end
    end
    fb_if.mem_ready = 1'b1;
    drain("rnd_drained");

    // clip counter saturation
    for (int i = 0; i < 300; i++) step(1, 200, i % 128, 0);
    step(0, 0, 0, 0);
    chk("clip_sat", clip_count, 255);

    // reset during a stalled write with the FIFO half full
    fb_if.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(1, i, 50, 1);
    chk("t6_we_before", fb_if.mem_we, 1);
    plot = 1'b0;
    resetn = 1'b0;
    #1;
    chk("t6_we", fb_if.mem_we, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_clip", clip_count, 0);
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    fb_if.mem_ready = 1'b1;
    log_addr.delete(); log_data.delete();
    repeat (10) step(0, 0, 0, 0);
    chk("t6_no_stale", log_addr.size(), 0);
    chk("t6_idle", busy, 0);
    step(1, 7, 7, 3);
    drain("t6_drained");
    chk("t6_nwrites", log_addr.size(), 1);
    if (log_addr.size() > 0) chk("t6_addr", log_addr[0], 1127);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
